// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I constants and the fetch-state enum
//   XLEN           : architectural register width
//   RV_NOP         : canonical NOP (addi x0,x0,0)
//   fetch_state_e  : instruction-fetch FSM states
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    KILL_REQ  = 3'd3,
    KILL_WAIT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer of {pc, instr} entries
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear        : drop all entries (wins over push)
//   push/push_data : write one entry (ignored when full)
//   pop/pop_data   : head entry is always on pop_data; pop advances it (ignored when empty)
//   count, empty, full : occupancy
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage feeding the IF/ID register
//   clk_i, rst_i            : clock, synchronous active-high reset
//   stall_i                 : hold the IF/ID outputs
//   redirect_i, redirect_pc_i : flush fetch and restart at the (word-aligned) target
//   imem_req_o, imem_addr_o : instruction memory request, address 0 when idle
//   imem_gnt_i, imem_rvalid_i, imem_rdata_i : memory grant and response
//   instruction_o, pc_address_o, if_valid_o : registered IF/ID entry
module if_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR  = RV_NOP,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_address_o,
  output logic            if_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  fetch_state_e      state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   req_pc;
  logic [XLEN-1:0]   target_pc;

  logic              fifo_push;
  logic              fifo_pop;
  logic [2*XLEN-1:0] fifo_push_data;
  logic [2*XLEN-1:0] fifo_pop_data;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

  assign target_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign fifo_push      = (state == WAIT) && imem_rvalid_i && !redirect_i;
  assign fifo_pop       = !redirect_i && !stall_i && !fifo_empty;
  assign fifo_push_data = {req_pc, imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear     (redirect_i),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Fetch FSM with registered request outputs. One request is outstanding at
  // most, and a new one is only issued while the FIFO has a free slot, so every
  // response has somewhere to land.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= '0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      if (redirect_i) pc <= target_pc;
      case (state)
        IDLE: begin
          if (!redirect_i && (fifo_count < DEPTH_CNT)) begin
            state       <= REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
          end
        end
        REQ: begin
          if (imem_gnt_i) begin
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
            req_pc      <= imem_addr_o;
            if (redirect_i) begin
              state <= KILL_WAIT;
            end else begin
              state <= WAIT;
              pc    <= pc + 32'd4;
            end
          end else if (redirect_i) begin
            // The bus request cannot be withdrawn; let it complete and discard it.
            state <= KILL_REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid_i)   state <= IDLE;
          else if (redirect_i) state <= KILL_WAIT;
        end
        KILL_REQ: begin
          if (imem_gnt_i) begin
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
            state       <= KILL_WAIT;
          end
        end
        KILL_WAIT: begin
          if (imem_rvalid_i) state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          imem_req_o  <= 1'b0;
          imem_addr_o <= '0;
        end
      endcase
    end
  end

  // IF/ID register; a redirect forces a bubble even under stall.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      instruction_o <= NOP_INSTR;
      pc_address_o  <= '0;
      if_valid_o    <= 1'b0;
    end else if (!stall_i) begin
      if (!fifo_empty) begin
        pc_address_o  <= fifo_pop_data[2*XLEN-1:XLEN];
        instruction_o <= fifo_pop_data[XLEN-1:0];
        if_valid_o    <= 1'b1;
      end else begin
        instruction_o <= NOP_INSTR;
        pc_address_o  <= '0;
        if_valid_o    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(fifo_push && fifo_full));
      assert (!(imem_rvalid_i && (state == IDLE || state == REQ || state == KILL_REQ)));
    end
  end

endmodule
